// File: rtl/flasher_pkg.sv
// flasher_pkg
//   Shared definitions for the flasher input stage: the debounce FSM state
//   encoding, default timing constants and a small constant helper used to
//   size counters.
//   Ports: none (package).
package flasher_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } flick_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_REPEAT_CYCLES   = 64;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Plain 1-bit two-flop synchronizer for an asynchronous level.
//   Ports:
//     clk   - destination clock
//     reset - asynchronous active-low reset, clears both flops to 0
//     d     - asynchronous input level
//     q     - synchronized level, two clk edges of latency
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/flick_conditioner.sv
// flick_conditioner
//   Cleans up the raw push-button level feeding the flasher: synchronizes
//   it, debounces press and release, and emits one registered single-cycle
//   pulse per accepted press together with a debounced level.
//   Optional feature: define FLICK_REPEAT_EN to emit an extra pulse every
//   REPEAT_CYCLES cycles while the button stays held.
//   Ports:
//     clk         - system clock, rising edge
//     reset       - asynchronous active-low reset
//     flick_raw   - raw, asynchronous, bouncy button level
//     flick       - one-cycle press pulse to the flasher (registered)
//     flick_level - debounced button level (registered)
//   The FSM state is kept in the signal `state` for observation.
import flasher_pkg::*;

module flick_conditioner #(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
  parameter int CNT_W           = $clog2(max2(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic flick_raw,
  output logic flick,
  output logic flick_level
);

  generate
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("flick_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s2;
  flick_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             flick_n;
  logic             level_n;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (flick_raw),
    .q     (s2)
  );

`ifdef FLICK_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rep_cnt <= '0;
    else        rep_cnt <= rep_cnt_n;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      flick       <= 1'b0;
      flick_level <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      flick       <= flick_n;
      flick_level <= level_n;
    end
  end

  // The debounce counter is cleared on every state change, so it never
  // needs to saturate or wrap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    flick_n = 1'b0;
`ifdef FLICK_REPEAT_EN
    rep_cnt_n = '0;
`endif
    case (state)
      IDLE: begin
        if (s2) begin
          state_n = PRESS_CHK;
          cnt_n   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          flick_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          state_n = RELEASE_CHK;
          cnt_n   = '0;
        end else begin
`ifdef FLICK_REPEAT_EN
          // Repeat pulses only while the button stays held; leaving HELD
          // (or coming back from RELEASE_CHK) restarts the period.
          if (rep_cnt == REP_LAST) begin
            flick_n   = 1'b1;
            rep_cnt_n = '0;
          end else begin
            rep_cnt_n = rep_cnt + CNT_W'(1);
          end
`endif
        end
      end
      RELEASE_CHK: begin
        if (s2) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    level_n = (state_n == HELD) || (state_n == RELEASE_CHK);
  end

endmodule
